// File: rtl/ntt_pkg.sv
// Shared NTT constants: coefficient width, modulus table, default multiplier
// latency and the Barrett constant helper used by modular_multiplier.
package ntt_pkg;

  localparam int DATA_W           = 30;
  localparam int MU_W             = DATA_W + 1;
  localparam int MULT_LAT_DEFAULT = 5;
  localparam int NUM_MOD          = 3;

  typedef logic [DATA_W-1:0] coeff_t;

  // All entries are NTT-friendly primes below 2^30 (k*2^n + 1).
  localparam coeff_t Q [NUM_MOD] = '{
    30'd998244353,
    30'd469762049,
    30'd754974721
  };

  // floor(2^(2k) / q) with k the bit length of q; q is never a power of two.
  function automatic logic [MU_W-1:0] barrett_mu(input coeff_t q);
    logic [63:0] num;
    num = 64'd1 << (2 * $clog2(q));
    return MU_W'(num / 64'(q));
  endfunction

endpackage

// File: rtl/ct_butterfly_if.sv
// Butterfly datapath bundle: operand/twiddle input side and result side.
// master = stage feeding the butterfly, slave = ct_butterfly itself.
interface ct_butterfly_if;
  import ntt_pkg::*;

  logic   in_valid;
  logic   in_last;
  coeff_t A;
  coeff_t B;
  coeff_t w;
  logic   out_valid;
  logic   out_last;
  coeff_t a;
  coeff_t b;
  logic   range_err;

  modport master (
    output in_valid, in_last, A, B, w,
    input  out_valid, out_last, a, b, range_err
  );

  modport slave (
    input  in_valid, in_last, A, B, w,
    output out_valid, out_last, a, b, range_err
  );

endinterface

// File: rtl/ct_delay_line.sv
// Fixed-depth shift register. RESET_EN selects whether the stages clear on
// rst_n (control bits) or run reset-free (wide data).
module ct_delay_line #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 1,
  parameter bit RESET_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  if (RESET_EN) begin : g_rst
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value; blocking here would collapse
    // the whole line into one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q <= stage_d;
      end
    end
  end else begin : g_no_rst
    // NOTE: wide data stages carry no reset; their contents are qualified by
    // the reset-able valid line, and skipping reset keeps them plain flops.
    always_ff @(posedge clk) begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/modular_adder.sv
// s = (x + y) mod Q[MOD_INDEX], one registered cycle, output clears on reset.
module modular_adder
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  coeff_t x,
  input  coeff_t y,
  output coeff_t s
);

  localparam coeff_t Q_M = Q[MOD_INDEX];

  logic [DATA_W:0] sum;
  coeff_t          s_d, s_q;

  always_comb begin
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= {1'b0, Q_M}) sum = sum - {1'b0, Q_M};
    s_d = sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

  assign s = s_q;

endmodule

// File: rtl/modular_multiplier.sv
// p = x*y mod Q[MOD_INDEX] with Barrett reduction, LAT cycles (LAT >= 3):
// product, quotient estimate, correction, then padding to LAT.
module modular_multiplier
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0,
  parameter int LAT       = MULT_LAT_DEFAULT
) (
  input  logic   clk,
  input  coeff_t x,
  input  coeff_t y,
  output coeff_t p
);

  localparam coeff_t          Q_M = Q[MOD_INDEX];
  localparam int              K   = $clog2(Q_M);
  localparam logic [MU_W-1:0] MU  = barrett_mu(Q_M);
  localparam int              PW  = 2 * DATA_W;
  localparam int              EW  = PW + MU_W;

  logic [PW-1:0] prod_d,  prod_q;
  logic [31:0]   prod2_d, prod2_q;
  logic [31:0]   qhat_d,  qhat_q;
  logic [31:0]   rem;
  coeff_t        red;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here unconditionally, up front) so no latch is inferred.
  always_comb begin
    prod_d  = PW'(x) * PW'(y);
    qhat_d  = 32'((EW'(prod_q >> (K - 1)) * EW'(MU)) >> (K + 1));
    // The true remainder is below 3q < 2^32, so low-word arithmetic suffices.
    prod2_d = prod_q[31:0];
    rem     = prod2_q - qhat_q * 32'(Q_M);
    if (rem >= 32'(Q_M)) rem = rem - 32'(Q_M);
    if (rem >= 32'(Q_M)) rem = rem - 32'(Q_M);
    red     = rem[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    prod_q  <= prod_d;
    prod2_q <= prod2_d;
    qhat_q  <= qhat_d;
  end

  ct_delay_line #(
    .WIDTH    (DATA_W),
    .DEPTH    (LAT - 2),
    .RESET_EN (1'b0)
  ) u_pad (
    .clk   (clk),
    .rst_n (1'b1),
    .d     (red),
    .q     (p)
  );

endmodule

// File: rtl/modular_subtractor.sv
// d = (x - y) mod Q[MOD_INDEX], one registered cycle, output clears on reset.
module modular_subtractor
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  coeff_t x,
  input  coeff_t y,
  output coeff_t d
);

  localparam coeff_t Q_M = Q[MOD_INDEX];

  coeff_t d_d, d_q;

  // x + (q - y) stays below q whenever x < y, so no carry bit is needed.
  always_comb begin
    if (x >= y) d_d = x - y;
    else        d_d = x + (Q_M - y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= '0;
    else        d_q <= d_d;
  end

  assign d = d_q;

endmodule

// File: rtl/ct_butterfly.sv
// Forward Cooley-Tukey butterfly, fully pipelined, latency MULT_LAT+1.
// Define CT_BUTTERFLY_RANGE_CHECK_EN to build the sticky operand range check.
module ct_butterfly
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0,
  parameter int MULT_LAT  = MULT_LAT_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  ct_butterfly_if.slave bus
);

  coeff_t     a_dly;
  coeff_t     t;
  coeff_t     sum;
  coeff_t     diff;
  logic [1:0] ctl_dly;

  ct_delay_line #(
    .WIDTH    (DATA_W),
    .DEPTH    (MULT_LAT),
    .RESET_EN (1'b0)
  ) u_a_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.A),
    .q     (a_dly)
  );

  // last is pre-qualified with valid so out_last can never fire alone.
  ct_delay_line #(
    .WIDTH    (2),
    .DEPTH    (MULT_LAT + 1),
    .RESET_EN (1'b1)
  ) u_ctl_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({bus.in_valid, bus.in_valid & bus.in_last}),
    .q     (ctl_dly)
  );

  modular_multiplier #(
    .MOD_INDEX (MOD_INDEX),
    .LAT       (MULT_LAT)
  ) u_mul (
    .clk (clk),
    .x   (bus.B),
    .y   (bus.w),
    .p   (t)
  );

  modular_adder #(
    .MOD_INDEX (MOD_INDEX)
  ) u_add (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (a_dly),
    .y     (t),
    .s     (sum)
  );

  modular_subtractor #(
    .MOD_INDEX (MOD_INDEX)
  ) u_sub (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (a_dly),
    .y     (t),
    .d     (diff)
  );

  assign bus.a         = sum;
  assign bus.b         = diff;
  assign bus.out_valid = ctl_dly[1];
  assign bus.out_last  = ctl_dly[0];

`ifdef CT_BUTTERFLY_RANGE_CHECK_EN
  localparam coeff_t Q_M = Q[MOD_INDEX];

  logic range_err_d, range_err_q;

  always_comb begin
    range_err_d = range_err_q |
                  (bus.in_valid & ((bus.A >= Q_M) | (bus.B >= Q_M) | (bus.w >= Q_M)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_err_q <= 1'b0;
    else        range_err_q <= range_err_d;
  end

  assign bus.range_err = range_err_q;
`else
  assign bus.range_err = 1'b0;
`endif

endmodule

// File: tb/tb_ct_butterfly.sv
// Scoreboard bench for ct_butterfly (q = 998244353, MULT_LAT = 5): the driver
// queues expected results, a negedge monitor pops and compares them.
module tb_ct_butterfly;
  import ntt_pkg::*;

  localparam logic [63:0] QV  = 64'd998244353;
  localparam logic [29:0] QM1 = 30'd998244352;
  localparam logic [29:0] QM2 = 30'd998244351;
  localparam logic [29:0] QQ  = 30'd998244353;
  localparam int          LAT = 6;
`ifdef CT_BUTTERFLY_RANGE_CHECK_EN
  localparam logic RC_EN = 1'b1;
`else
  localparam logic RC_EN = 1'b0;
`endif

  typedef struct {
    logic [29:0] a;
    logic [29:0] b;
    logic        last;
    bit          chk;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ct_butterfly_if bus ();

  ct_butterfly #(
    .MOD_INDEX (0),
    .MULT_LAT  (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [29:0] ai, bi, wi, output logic [29:0] ea, eb);
    logic [63:0] t;
    t  = (64'(bi) * 64'(wi)) % QV;
    ea = 30'((64'(ai) + t) % QV);
    eb = 30'((64'(ai) + QV - t) % QV);
  endfunction

  task automatic send(input logic [29:0] ai, bi, wi, input logic last,
                      input logic [29:0] ea, eb, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.A        = ai;
    bus.B        = bi;
    bus.w        = wi;
    e.a = ea; e.b = eb; e.last = last; e.chk = chk; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every out_valid must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_last && !bus.out_valid) check("last_without_valid", 64'(bus.out_last), 64'd0);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("latency", 64'(cyc - mon_e.cyc), 64'(LAT));
          check("out_last", 64'(bus.out_last), 64'(mon_e.last));
          if (mon_e.chk) begin
            check("a", 64'(bus.a), 64'(mon_e.a));
            check("b", 64'(bus.b), 64'(mon_e.b));
          end
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc + LAT) begin
        check("missing_out_valid", 64'(bus.out_valid), 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [29:0] ra, rb, rw, ea, eb;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.A = '0; bus.B = '0; bus.w = '0;

    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    check("rst_a",         64'(bus.a),         64'd0);
    check("rst_b",         64'(bus.b),         64'd0);
    check("rst_range_err", 64'(bus.range_err), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(8);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);

    // Basic: t = 6.
    send(30'd5, 30'd3, 30'd2, 1'b0, 30'd11, QM1, 1'b1);
    idle(1);
    drain();

    // Boundaries: (q-1)^2 = 1, 2(q-1) = q-2, 2^30 mod q = 75497471.
    send(30'd0,     30'd1,     30'd1,     1'b0, 30'd1,        QM1,           1'b1);
    send(QM1,       QM1,       30'd1,     1'b0, QM2,          30'd0,         1'b1);
    send(30'd12345, 30'd777,   30'd0,     1'b0, 30'd12345,    30'd12345,     1'b1);
    send(30'd100,   30'd10,    30'd10,    1'b0, 30'd200,      30'd0,         1'b1);
    send(30'd7,     QM1,       QM1,       1'b0, 30'd8,        30'd6,         1'b1);
    send(30'd3,     QM1,       30'd2,     1'b0, 30'd1,        30'd5,         1'b1);
    send(30'd0,     30'd32768, 30'd32768, 1'b0, 30'd75497471, 30'd922746882, 1'b1);
    idle(1);
    drain();

    // Bubbles: valid pattern 1,0,1,1,0.
    send(30'd1, 30'd1, 30'd1, 1'b0, 30'd2,  30'd0,         1'b1);
    idle(1);
    send(30'd2, 30'd3, 30'd4, 1'b0, 30'd14, 30'd998244343, 1'b1);
    send(30'd9, 30'd1, 30'd9, 1'b0, 30'd18, 30'd0,         1'b1);
    idle(1);
    drain();

    // Streaming: 64 back-to-back random triples, last on the final one.
    for (int i = 0; i < 64; i++) begin
      ra = 30'($urandom_range(0, 32'd998244352));
      rb = 30'($urandom_range(0, 32'd998244352));
      rw = 30'($urandom_range(0, 32'd998244352));
      model(ra, rb, rw, ea, eb);
      send(ra, rb, rw, i == 63, ea, eb, 1'b1);
    end
    idle(1);
    drain();

    // Mid-operation reset: in-flight butterflies must vanish.
    send(30'd11, 30'd22, 30'd33, 1'b0, 30'd0, 30'd0, 1'b1);
    send(30'd44, 30'd55, 30'd66, 1'b1, 30'd0, 30'd0, 1'b1);
    send(30'd77, 30'd88, 30'd99, 1'b0, 30'd0, 30'd0, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst_n        = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_a",         64'(bus.a),         64'd0);
    check("midrst_b",         64'(bus.b),         64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    send(30'd5, 30'd3, 30'd2, 1'b0, 30'd11, QM1, 1'b1);
    idle(1);
    drain();

    // Range check: B = q.
    check("range_err_before", 64'(bus.range_err), 64'd0);
    send(30'd1, QQ, 30'd1, 1'b0, 30'd0, 30'd0, 1'b0);
    idle(1);
    check("range_err_set", 64'(bus.range_err), 64'(RC_EN));
    idle(4);
    check("range_err_held", 64'(bus.range_err), 64'(RC_EN));
    drain();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("range_err_reset", 64'(bus.range_err), 64'd0);
    #3 rst_n = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_butterfly.md
CT_BUTTERFLY -- requirements
Module: ct_butterfly

Interface
REQ-001 The block SHALL have parameter MOD_INDEX, default 0, which selects the modulus q = Q[MOD_INDEX] from the shared package.
REQ-002 The block SHALL have parameter MULT_LAT, default 5, which is the latency in cycles of modular_multiplier.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  A, B and w are valid this cycle.
REQ-006 in_last  in  1  final butterfly of the current NTT stage.
REQ-007 A, B, w  in  30 each  operands and twiddle factor, each in the range [0, q).
REQ-008 out_valid  out  1  a and b are valid this cycle.
REQ-009 out_last  out  1  in_last, delayed to match a and b.
REQ-010 a, b  out  30 each  butterfly results.
REQ-011 range_err  out  1  sticky flag for an out-of-range operand (see Configuration).

Function
REQ-012 The block SHALL compute the forward Cooley-Tukey butterfly: t = B*w mod q; a = (A + t) mod q; b = (A - t) mod q.
REQ-013 B and w SHALL feed modular_multiplier directly.
REQ-014 A SHALL be delayed MULT_LAT cycles so that it aligns with t.
REQ-015 modular_adder and modular_subtractor (1 registered cycle each) SHALL then consume the delayed A and t.
REQ-016 Total latency from in_valid to out_valid SHALL be exactly MULT_LAT+1 cycles (6 at default).
REQ-017 The block SHALL accept a new operand set every cycle; there is no backpressure and no stall.
REQ-018 in_valid and in_last SHALL travel through a reset-able delay line of MULT_LAT+1 stages.
REQ-019 out_last SHALL be asserted only when out_valid is asserted.
REQ-020 Data registers SHALL capture every cycle regardless of valid; only the valid and last pipelines carry reset.
REQ-021 When out_valid=0, the values on a and b are don't-care.
REQ-022 All arithmetic SHALL be fully reduced; outputs SHALL always lie in [0, q) for in-range inputs.
REQ-023 Boundary: A = t SHALL give a = 2A mod q and b = 0.
REQ-024 Boundary: A = 0 with t > 0 SHALL give b = q - t.
REQ-025 Boundary: w = 0 SHALL give a = b = A.
REQ-026 Gaps in in_valid SHALL propagate unchanged; bubbles are preserved cycle for cycle.

Reset
REQ-027 When rst_n=0, out_valid, out_last, range_err and every valid/last pipeline stage SHALL clear to 0 immediately.
REQ-028 After rst_n is released, out_valid SHALL stay 0 until MULT_LAT+1 cycles after the first in_valid.
REQ-029 Butterflies in flight when reset is asserted mid-operation SHALL be discarded; no out_valid SHALL appear for them.
REQ-030 a and b SHALL reset to 0.

Configuration
REQ-031 The macro CT_BUTTERFLY_RANGE_CHECK_EN SHALL enable the operand range check.
REQ-032 With CT_BUTTERFLY_RANGE_CHECK_EN defined, range_err SHALL set 1 cycle after any in_valid cycle with A >= q, B >= q or w >= q.
REQ-033 Once set, range_err SHALL hold until rst_n is asserted.
REQ-034 With CT_BUTTERFLY_RANGE_CHECK_EN undefined, range_err SHALL be tied to 0 and no comparators SHALL be synthesized.

Structure
REQ-035 Package ntt_pkg SHALL hold the modulus table Q[], the data width constant (30) and the default MULT_LAT.
REQ-036 The block SHALL reuse the existing modular_multiplier, modular_adder and modular_subtractor, each instantiated with MOD_INDEX.
REQ-037 The block SHALL contain one new sub-module, ct_delay_line (parameters WIDTH, DEPTH, RESET_EN), used for both the A delay and the valid/last delay.

Verification
REQ-038 Basic: A=5, B=3, w=2 with in_valid for 1 cycle -> out_valid 6 cycles later; a=11, b=q-1; out_last=0.
REQ-039 Streaming: 64 back-to-back random in-range triples with in_last on the 64th -> 64 consecutive out_valid cycles matching the reference model; out_last only on the 64th.
REQ-040 Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid shows the same pattern shifted by 6 cycles.
REQ-041 Boundaries: (A=0, B=1, w=1) -> a=1, b=q-1; (A=q-1, B=q-1, w=1) -> a=q-2, b=0; w=0 -> a=b=A.
REQ-042 Mid-operation reset: 3 valid inputs, rst_n pulsed low at cycle 3 -> no out_valid afterwards; a fresh input completes 6 cycles after it is applied.
REQ-043 Range check with CT_BUTTERFLY_RANGE_CHECK_EN defined: B=q -> range_err=1 one cycle later and held; without the macro, range_err stays 0.
